// File: rtl/lc3_pkg.sv
// Shared LC3 memory-side definitions: word width, MMIO register addresses and
// the responder state encoding.
package lc3_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] KBSR_ADDR = 16'hFE00;
    localparam logic [WORD_W-1:0] KBDR_ADDR = 16'hFE02;
    localparam logic [WORD_W-1:0] DSR_ADDR  = 16'hFE04;
    localparam logic [WORD_W-1:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } resp_state_e;

endpackage

// File: rtl/lc3_mem_ram.sv
// Single-port word RAM, 2^ADDR_W x 16; read data appears one cycle after an
// enabled read and holds until the next enabled read. No backpressure.
module lc3_mem_ram
    import lc3_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC3 memory responder (RAM + KBSR/KBDR/DSR/DDR); response 2 cycles after accept,
// +WAIT_CYCLES with LC3_MEM_WAITSTATE_EN; one transaction in flight, RESP holds until resp_ready.
module lc3_mem_responder
    import lc3_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    input  logic              kbd_strobe,
    input  logic [7:0]        kbd_char,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [7:0]        disp_char
);

    resp_state_e       state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              from_ram_q, from_ram_d;
    logic              kb_rdy_q, kb_rdy_d;
    logic              kb_ovr_q, kb_ovr_d;
    logic [7:0]        kb_char_q, kb_char_d;
    logic              disp_valid_q, disp_valid_d;
    logic [7:0]        disp_char_q, disp_char_d;
    logic              kb_consume;

`ifdef LC3_MEM_WAITSTATE_EN
    logic [3:0]        wait_cnt_q, wait_cnt_d;
`else
    logic [3:0]        unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
`endif

    logic              is_kbsr, is_kbdr, is_dsr, is_ddr, is_ram;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    assign is_kbsr = (addr_q == KBSR_ADDR);
    assign is_kbdr = (addr_q == KBDR_ADDR);
    assign is_dsr  = (addr_q == DSR_ADDR);
    assign is_ddr  = (addr_q == DDR_ADDR);
    assign is_ram  = !(is_kbsr || is_kbdr || is_dsr || is_ddr)
                     && (32'(addr_q) < (32'd1 << ADDR_W));

    // Gating with reset keeps an abandoned write from committing.
    assign ram_en = (state_q == S_ACCESS) && is_ram && !reset;

    lc3_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[ADDR_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        from_ram_d   = from_ram_q;
        kb_rdy_d     = kb_rdy_q;
        kb_ovr_d     = kb_ovr_q;
        kb_char_d    = kb_char_q;
        disp_valid_d = disp_valid_q;
        disp_char_d  = disp_char_q;
        kb_consume   = 1'b0;
`ifdef LC3_MEM_WAITSTATE_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d    = '0;
                from_ram_d = is_ram && !we_q;
                if (!we_q) begin
                    if (is_kbsr) begin
                        rdata_d  = {kb_rdy_q, kb_ovr_q, 14'b0};
                        kb_ovr_d = 1'b0;
                    end
                    if (is_kbdr) begin
                        rdata_d    = {8'h00, kb_char_q};
                        kb_consume = 1'b1;
                    end
                    if (is_dsr) begin
                        rdata_d = {~disp_valid_q, 15'b0};
                    end
                end else if (is_ddr && !disp_valid_q) begin
                    disp_valid_d = 1'b1;
                    disp_char_d  = wdata_q[7:0];
                end
`ifdef LC3_MEM_WAITSTATE_EN
                if (WAIT_CYCLES > 0) begin
                    wait_cnt_d = 4'(WAIT_CYCLES - 1);
                    state_d    = S_WAIT;
                end else begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
`else
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
`endif
            end
`ifdef LC3_MEM_WAITSTATE_EN
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
`endif
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    rdata_d      = '0;
                    from_ram_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = S_IDLE;
            end
        endcase

        if (disp_valid_q && disp_ready) begin
            disp_valid_d = 1'b0;
        end

        // A char consumed in this cycle frees the slot for a simultaneous strobe.
        if (kbd_strobe) begin
            if (kb_rdy_q && !kb_consume) begin
                kb_ovr_d = 1'b1;
            end else begin
                kb_char_d = kbd_char;
                kb_rdy_d  = 1'b1;
            end
        end else if (kb_consume) begin
            kb_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            from_ram_q   <= 1'b0;
            kb_rdy_q     <= 1'b0;
            kb_ovr_q     <= 1'b0;
            kb_char_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_char_q  <= '0;
`ifdef LC3_MEM_WAITSTATE_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            from_ram_q   <= from_ram_d;
            kb_rdy_q     <= kb_rdy_d;
            kb_ovr_q     <= kb_ovr_d;
            kb_char_q    <= kb_char_d;
            disp_valid_q <= disp_valid_d;
            disp_char_q  <= disp_char_d;
`ifdef LC3_MEM_WAITSTATE_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = from_ram_q ? ram_rdata : rdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_char  = disp_char_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: directed scenarios plus random RAM traffic
// checked against a memory-map model of RAM, keyboard and display.
module tb_lc3_mem_responder;
    import lc3_pkg::*;

`ifdef LC3_MEM_WAITSTATE_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_rdata;
    logic        kbd_strobe;
    logic [7:0]  kbd_char;
    logic        disp_valid, disp_ready;
    logic [7:0]  disp_char;

    always #5 clk = ~clk;

    lc3_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .kbd_strobe (kbd_strobe),
        .kbd_char   (kbd_char),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_char  (disp_char)
    );

    int errors = 0;
    int checks = 0;

    // Reference state of the memory map
    logic [15:0] ram_m [int];
    int          wr_list[$];
    bit          kb_rdy_m, kb_ovr_m, disp_v_m;
    logic [7:0]  kb_char_m, disp_c_m;

    function automatic void model_reset();
        kb_rdy_m  = 0;
        kb_ovr_m  = 0;
        kb_char_m = 8'h00;
        disp_v_m  = 0;
        disp_c_m  = 8'h00;
    endfunction

    function automatic void model_strobe(input logic [7:0] c);
        if (!kb_rdy_m) begin
            kb_char_m = c;
            kb_rdy_m  = 1;
        end else begin
            kb_ovr_m = 1;
        end
    endfunction

    function automatic logic [15:0] model_access(input bit we, input logic [15:0] a,
                                                 input logic [15:0] wd, input bit strobe,
                                                 input logic [7:0] sc);
        logic [15:0] rd;
        bit consumed;
        rd = 16'h0000;
        consumed = 0;
        if (a == 16'hFE00) begin
            if (!we) begin
                rd = {kb_rdy_m, kb_ovr_m, 14'b0};
                kb_ovr_m = 0;
            end
        end else if (a == 16'hFE02) begin
            if (!we) begin
                rd = {8'h00, kb_char_m};
                consumed = 1;
            end
        end else if (a == 16'hFE04) begin
            if (!we) rd = disp_v_m ? 16'h0000 : 16'h8000;
        end else if (a == 16'hFE06) begin
            if (we && !disp_v_m) begin
                disp_v_m = 1;
                disp_c_m = wd[7:0];
            end
        end else if (int'(a) < 4096) begin
            if (we) begin
                ram_m[int'(a)] = wd;
                wr_list.push_back(int'(a));
            end else begin
                rd = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'h0000;
            end
        end
        if (consumed) kb_rdy_m = 0;
        if (strobe) model_strobe(sc);
        return rd;
    endfunction

    // Full transaction starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic txn(input bit we, input logic [15:0] a, input logic [15:0] wd,
                       input int stall, input bit strobe_acc, input logic [7:0] sc,
                       input string nm);
        logic [15:0] exp;
        int lat;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b want 1", nm, req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        if (stall == 0) req_valid = 1'b0;
        if (strobe_acc) begin
            kbd_strobe = 1'b1;
            kbd_char   = sc;
        end
        exp = model_access(we, a, wd, strobe_acc, sc);
        lat = 1;
        while (lat < 40) begin
            if (resp_valid === 1'b1) break;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_ready lat=%0d: got %b want 0", nm, lat, req_ready);
            end
            @(negedge clk);
            kbd_strobe = 1'b0;
            lat++;
        end
        kbd_strobe = 1'b0;
        checks++;
        if (lat != EXP_LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, EXP_LAT);
        end
        checks++;
        if (resp_rdata !== exp) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", nm, resp_rdata, exp);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                         nm, s, resp_valid, resp_rdata, req_ready, exp);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_hs: got v=%b rdy=%b want v=0 rdy=1", nm, resp_valid, req_ready);
        end
    endtask

    task automatic kbd_push(input logic [7:0] c);
        kbd_strobe = 1'b1;
        kbd_char   = c;
        @(posedge clk);
        @(negedge clk);
        kbd_strobe = 1'b0;
        model_strobe(c);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 16'h0 ||
            disp_valid !== 1'b0 || disp_char !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h dv=%b dc=%h want 1 0 0000 0 00",
                     req_ready, resp_valid, resp_rdata, disp_valid, disp_char);
        end
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "reset_kbsr");
        txn(0, KBDR_ADDR, 16'h0, 0, 0, 8'h0, "reset_kbdr");
    endtask

    task automatic test_ram_basic();
        txn(1, 16'h0010, 16'h1234, 0, 0, 8'h0, "wr_0010");
        txn(0, 16'h0010, 16'h0,    0, 0, 8'h0, "rd_0010");
        txn(1, 16'h0000, 16'h5555, 0, 0, 8'h0, "wr_0000");
        txn(1, 16'h0FFF, 16'hCAFE, 0, 0, 8'h0, "wr_0fff");
        txn(1, 16'h1000, 16'hAAAA, 0, 0, 8'h0, "wr_1000");
        txn(0, 16'h1000, 16'h0,    0, 0, 8'h0, "rd_1000");
        txn(0, 16'h0000, 16'h0,    0, 0, 8'h0, "rd_0000_alias");
        txn(0, 16'h0FFF, 16'h0,    0, 0, 8'h0, "rd_0fff");
        txn(0, DDR_ADDR, 16'h0,    0, 0, 8'h0, "rd_ddr");
    endtask

    task automatic test_stall();
        txn(0, 16'h0010, 16'h0, 5, 0, 8'h0, "stall_rd");
        txn(0, DSR_ADDR, 16'h0, 3, 0, 8'h0, "stall_dsr");
    endtask

    task automatic test_kbd();
        kbd_push(8'h41);
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "kbsr_ready");
        txn(0, KBDR_ADDR, 16'h0, 0, 0, 8'h0, "kbdr_41");
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "kbsr_clear");
        kbd_push(8'h41);
        kbd_push(8'h42);
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "kbsr_ovr");
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "kbsr_ovr_clr");
        txn(1, KBSR_ADDR, 16'hFFFF, 0, 0, 8'h0, "wr_kbsr_ign");
        txn(0, KBDR_ADDR, 16'h0, 0, 0, 8'h0, "kbdr_keep41");
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "kbsr_empty");
        kbd_push(8'h43);
        txn(0, KBDR_ADDR, 16'h0, 0, 1, 8'h44, "kbdr_race");
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "kbsr_race");
        txn(0, KBDR_ADDR, 16'h0, 0, 0, 8'h0, "kbdr_44");
    endtask

    task automatic test_disp();
        disp_ready = 1'b0;
        txn(1, DDR_ADDR, 16'h0058, 0, 0, 8'h0, "ddr_wr58");
        checks++;
        if (disp_valid !== disp_v_m || disp_char !== disp_c_m) begin
            errors++;
            $display("FAIL disp_set: got v=%b c=%h want v=%b c=%h", disp_valid, disp_char, disp_v_m, disp_c_m);
        end
        txn(0, DSR_ADDR, 16'h0, 0, 0, 8'h0, "dsr_busy");
        txn(1, DDR_ADDR, 16'h0059, 0, 0, 8'h0, "ddr_wr59_ign");
        txn(1, DSR_ADDR, 16'hFFFF, 0, 0, 8'h0, "wr_dsr_ign");
        checks++;
        if (disp_valid !== disp_v_m || disp_char !== disp_c_m) begin
            errors++;
            $display("FAIL disp_hold: got v=%b c=%h want v=%b c=%h", disp_valid, disp_char, disp_v_m, disp_c_m);
        end
        disp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        disp_ready = 1'b0;
        disp_v_m = 0;
        checks++;
        if (disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL disp_drain: got %b want 0", disp_valid);
        end
        txn(0, DSR_ADDR, 16'h0, 0, 0, 8'h0, "dsr_free");
    endtask

    task automatic test_random();
        logic [15:0] a, d;
        int op, st;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            st = $urandom_range(0, 2);
            d  = 16'($urandom);
            if (op == 1 && wr_list.size() > 0) begin
                a = 16'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
                txn(0, a, 16'h0, st, 0, 8'h0, "rnd_rd");
            end else if (op == 2) begin
                a = 16'($urandom_range(16'h1000, 16'hFDFF));
                txn(($urandom_range(0, 1) == 1), a, d, st, 0, 8'h0, "rnd_oor");
            end else begin
                a = 16'($urandom_range(0, 4095));
                txn(1, a, d, st, 0, 8'h0, "rnd_wr");
            end
        end
        for (int i = 0; i < 8 && i < wr_list.size(); i++) begin
            txn(0, 16'(wr_list[i]), 16'h0, 0, 0, 8'h0, "rnd_final");
        end
    endtask

    task automatic test_reset_in_access();
        txn(1, 16'h0020, 16'h0BAD, 0, 0, 8'h0, "pre_wr_0020");
        kbd_push(8'h55);
        txn(1, DDR_ADDR, 16'h0033, 0, 0, 8'h0, "pre_ddr");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || disp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_access%0d: got v=%b rdy=%b dv=%b want 0 1 0", i, resp_valid, req_ready, disp_valid);
            end
            @(negedge clk);
        end
        txn(0, 16'h0020, 16'h0, 0, 0, 8'h0, "rst_rd_0020");
        txn(0, 16'h0010, 16'h0, 0, 0, 8'h0, "rst_rd_0010");
        txn(0, KBSR_ADDR, 16'h0, 0, 0, 8'h0, "rst_kbsr");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 16'h0;
        resp_ready = 1'b1;
        kbd_strobe = 1'b0;
        kbd_char   = 8'h0;
        disp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_ram_basic();
        test_stall();
        test_kbd();
        test_disp();
        test_random();
        test_reset_in_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
